pipe_skid_chain: RTL and testbench
==================================

PIPE_SKID_CHAIN -- requirements
Module: pipe_skid_chain

Interface
REQ-001 SHALL have parameter N, default 32: data width in bits, N >= 1.
REQ-002 SHALL have parameter DEPTH, default 1: number of chained skid stages, DEPTH >= 1.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port a_reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port flush  input  1  synchronous clear of all stages.
REQ-006 SHALL have port hold  input  1  synchronous freeze of the whole chain.
REQ-007 SHALL have port in_valid  input  1  upstream data valid.
REQ-008 SHALL have port in_data  input  N  upstream data.
REQ-009 SHALL have port in_ready  output  1  chain accepts in_data this cycle.
REQ-010 SHALL have port out_valid  output  1  out_data valid.
REQ-011 SHALL have port out_data  output  N  downstream data.
REQ-012 SHALL have port out_ready  input  1  downstream accepts this cycle.
REQ-013 SHALL have port occupancy  output  OW  number of held entries, 0..2*DEPTH, where OW = clog2(2*DEPTH+1).

Function
REQ-014 Transfers SHALL occur only on the rising edge of clk: input fire = in_valid & in_ready; output fire = out_valid & out_ready.
REQ-015 Each stage SHALL hold a main register and a skid register and be in one of three states: EMPTY (0 entries), HALF (main only) or FULL (main and skid).
REQ-016 Stage transitions SHALL be as follows. EMPTY + in-fire -> HALF, main <= in.
REQ-017 HALF + in-fire + out-fire -> HALF, main <= in.
REQ-018 HALF + in-fire without out-fire -> FULL, skid <= in.
REQ-019 HALF + out-fire without in-fire -> EMPTY.
REQ-020 FULL + out-fire -> HALF, main <= skid.
REQ-021 FULL SHALL accept no input.
REQ-022 A stage's input ready SHALL be (state != FULL), taken from a register only, with no combinational path from out_ready to in_ready.
REQ-023 Stage k output SHALL drive stage k+1 input; stage 0 SHALL face in_*; stage DEPTH-1 SHALL face out_*.
REQ-024 Latency SHALL be DEPTH cycles from input fire to out_valid on an empty chain.
REQ-025 Sustained throughput SHALL be 1 transfer per cycle while out_ready = 1.
REQ-026 Ordering SHALL be strict FIFO; no data is dropped or duplicated.
REQ-027 out_data SHALL equal the last stage's main register at all times; the value is don't-care to consumers when out_valid = 0.
REQ-028 flush SHALL, on the next edge, set every stage to EMPTY and zero every main and skid register; a simultaneous in-fire is discarded.
REQ-029 flush SHALL take priority over hold and over all handshakes.
REQ-030 hold = 1 SHALL force in_ready = 0 and out_valid = 0 combinationally, with no state or data change.
REQ-031 occupancy SHALL equal the sum over stages of (HALF ? 1 : FULL ? 2 : 0), updated in the same edge as the state.
REQ-032 in_valid SHALL be permitted to deassert without acceptance, with no effect on the chain.

Reset
REQ-033 a_reset = 1 SHALL immediately, without a clock, set all stages to EMPTY and all data registers to 0.
REQ-034 While and after a_reset, out_valid SHALL be 0, occupancy 0, in_ready 1 (0 if hold = 1) and out_data 0.
REQ-035 Reset asserted mid-transfer SHALL abort the transfer; no partial state survives.

Structure
REQ-036 Stage state encodings (EMPTY = 2'b00, HALF = 2'b01, FULL = 2'b10) and the OW width function SHALL reside in the shared package pipe_pkg.
REQ-037 One stage SHALL be the sub-module skid_slot (params N; ports clk, a_reset, flush, in/out handshake, 2-bit state output), instantiated DEPTH times by a generate loop.

Verification
REQ-038 N=32, DEPTH=1: push 0xA5A5A5A5 with out_ready=1 -> out_valid next cycle with out_data 0xA5A5A5A5, occupancy 1, then 0 after pop.
REQ-039 DEPTH=2, out_ready=0: push 0x1,0x2,0x3,0x4 -> all accepted, in_ready=0 after 4th, occupancy 4; then out_ready=1 -> outputs 0x1..0x4 in order on consecutive cycles.
REQ-040 DEPTH=1, streaming 100 words with out_ready toggling 1,0 -> all words received in order, none lost, in_ready never depends same-cycle on out_ready.
REQ-041 Occupancy 3, assert flush with in_valid=1 and hold=1 -> next cycle occupancy 0, out_valid 0, all data 0, the input not captured.
REQ-042 Occupancy 2, hold=1 for 5 cycles with in_valid=1 and out_ready=1 -> in_ready=0 and out_valid=0 throughout, occupancy stays 2, data intact after release.
REQ-043 Assert a_reset between clock edges while FULL -> out_valid=0 and occupancy=0 before the next edge.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the skid-buffer chain: slot state encodings and the
// occupancy width helper.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_HALF  = 2'b01,
        ST_FULL  = 2'b10
    } slot_state_e;

    // Width needed to count 0..2*depth held entries.
    function automatic int occ_w(input int depth);
        return $clog2(2 * depth + 1);
    endfunction

endpackage

// File: rtl/skid_slot.sv
// One two-entry skid stage: main register feeds the output, skid catches the
// word that arrives while the output is stalled.
module skid_slot
    import pipe_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         a_reset,
    input  logic         flush,
    input  logic         in_valid,
    input  logic [N-1:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [N-1:0] out_data,
    input  logic         out_ready,
    output logic [1:0]   state
);

    slot_state_e  state_q, state_d;
    logic [N-1:0] main_q, main_d;
    logic [N-1:0] skid_q, skid_d;
    logic         in_fire, out_fire;

    // Ready comes straight from the state register, so out_ready never
    // reaches in_ready combinationally.
    assign in_ready  = (state_q != ST_FULL);
    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = main_q;
    assign state     = state_q;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d = ST_HALF;
                        main_d  = in_data;
                    end
                end
                ST_HALF: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data;
                    end else if (in_fire) begin
                        state_d = ST_FULL;
                        skid_d  = in_data;
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_fire) begin
                        state_d = ST_HALF;
                        main_d  = skid_q;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge a_reset) begin
        if (a_reset) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: rtl/pipe_skid_chain.sv
// Chain of DEPTH skid stages with global flush/hold and an occupancy count.
// hold masks every handshake in the chain so nothing moves while it is set.
module pipe_skid_chain
    import pipe_pkg::*;
#(
    parameter int N     = 32,
    parameter int DEPTH = 1
) (
    input  logic                       clk,
    input  logic                       a_reset,
    input  logic                       flush,
    input  logic                       hold,
    input  logic                       in_valid,
    input  logic [N-1:0]               in_data,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [N-1:0]               out_data,
    input  logic                       out_ready,
    output logic [occ_w(DEPTH)-1:0]    occupancy
);

    localparam int OW = occ_w(DEPTH);

    logic [DEPTH-1:0]        s_in_valid, s_in_ready, s_out_valid, s_out_ready;
    logic [DEPTH-1:0][N-1:0] s_in_data, s_out_data;
    logic [DEPTH-1:0][1:0]   s_state;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign s_in_valid[k] = in_valid & ~hold;
            assign s_in_data[k]  = in_data;
        end else begin : g_link
            assign s_in_valid[k] = s_out_valid[k-1] & ~hold;
            assign s_in_data[k]  = s_out_data[k-1];
        end
        if (k == DEPTH - 1) begin : g_tail
            assign s_out_ready[k] = out_ready & ~hold;
        end else begin : g_next
            assign s_out_ready[k] = s_in_ready[k+1] & ~hold;
        end

        skid_slot #(.N(N)) u_slot (
            .clk       (clk),
            .a_reset   (a_reset),
            .flush     (flush),
            .in_valid  (s_in_valid[k]),
            .in_data   (s_in_data[k]),
            .in_ready  (s_in_ready[k]),
            .out_valid (s_out_valid[k]),
            .out_data  (s_out_data[k]),
            .out_ready (s_out_ready[k]),
            .state     (s_state[k])
        );
    end

    assign in_ready  = s_in_ready[0] & ~hold;
    assign out_valid = s_out_valid[DEPTH-1] & ~hold;
    assign out_data  = s_out_data[DEPTH-1];

    // The state encoding doubles as the entry count (HALF=1, FULL=2).
    always_comb begin
        occupancy = '0;
        for (int k = 0; k < DEPTH; k++) begin
            occupancy = occupancy + OW'(s_state[k]);
        end
    end

endmodule

// File: tb/tb_pipe_skid_chain.sv
// Bench for pipe_skid_chain: a DEPTH=1 and a DEPTH=2 instance driven from
// a vector table, hand sequences and a queue scoreboard.
module tb_pipe_skid_chain;

    logic clk = 1'b0;
    logic a_reset;
    always #5 clk = ~clk;

    logic        f1, h1, iv1, ir1, ov1, or1;
    logic [31:0] id1, od1;
    logic [1:0]  oc1;
    logic        f2, h2, iv2, ir2, ov2, or2;
    logic [31:0] id2, od2;
    logic [2:0]  oc2;

    pipe_skid_chain #(.N(32), .DEPTH(1)) dut1 (
        .clk(clk), .a_reset(a_reset), .flush(f1), .hold(h1),
        .in_valid(iv1), .in_data(id1), .in_ready(ir1),
        .out_valid(ov1), .out_data(od1), .out_ready(or1), .occupancy(oc1)
    );

    pipe_skid_chain #(.N(32), .DEPTH(2)) dut2 (
        .clk(clk), .a_reset(a_reset), .flush(f2), .hold(h2),
        .in_valid(iv2), .in_data(id2), .in_ready(ir2),
        .out_valid(ov2), .out_data(od2), .out_ready(or2), .occupancy(oc2)
    );

    int total = 0;
    int bad   = 0;
    logic [31:0] sb[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic sb_pop(input string nm, input logic [31:0] act);
        if (sb.size() == 0) chk({nm, "_unexpected"}, 32'd1, 32'd0);
        else chk(nm, act, sb.pop_front());
    endtask

    typedef struct {
        logic        iv;
        logic [31:0] id;
        logic        ordy;
        logic        e_ir;
        logic        e_ov;
        logic [31:0] e_od;
        logic [2:0]  e_occ;
    } vec_t;

    vec_t tbl[10];

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent, recv, cyc;

        // DEPTH=2, out_ready low: four pushes fill both stages, then drain
        tbl[0] = '{1'b1, 32'h1, 1'b0, 1'b1, 1'b0, 32'h0, 3'd0};
        tbl[1] = '{1'b1, 32'h2, 1'b0, 1'b1, 1'b0, 32'h0, 3'd1};
        tbl[2] = '{1'b1, 32'h3, 1'b0, 1'b1, 1'b1, 32'h1, 3'd2};
        tbl[3] = '{1'b1, 32'h4, 1'b0, 1'b1, 1'b1, 32'h1, 3'd3};
        tbl[4] = '{1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h1, 3'd4};
        tbl[5] = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h1, 3'd4};
        tbl[6] = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h2, 3'd3};
        tbl[7] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h3, 3'd2};
        tbl[8] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h4, 3'd1};
        tbl[9] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 3'd0};

        {f1, h1, iv1, or1} = '0; id1 = '0;
        {f2, h2, iv2, or2} = '0; id2 = '0;
        a_reset = 1'b1;

        // reset values
        repeat (2) @(negedge clk);
        h1 = 1'b1; #1;
        chk("rst_ir_hold", {31'd0, ir1}, 32'd0);
        h1 = 1'b0; #1;
        chk("rst_ov1", {31'd0, ov1}, 32'd0);
        chk("rst_occ1", {30'd0, oc1}, 32'd0);
        chk("rst_ir1", {31'd0, ir1}, 32'd1);
        chk("rst_od1", od1, 32'd0);
        chk("rst_ov2", {31'd0, ov2}, 32'd0);
        chk("rst_occ2", {29'd0, oc2}, 32'd0);
        a_reset = 1'b0;

        // single word through DEPTH=1
        @(negedge clk); iv1 = 1'b1; id1 = 32'hA5A5A5A5; or1 = 1'b1; #1;
        chk("d1_first_ir", {31'd0, ir1}, 32'd1);
        @(negedge clk); iv1 = 1'b0; #1;
        chk("d1_first_ov", {31'd0, ov1}, 32'd1);
        chk("d1_first_od", od1, 32'hA5A5A5A5);
        chk("d1_first_occ", {30'd0, oc1}, 32'd1);
        @(negedge clk); #1;
        chk("d1_after_pop_ov", {31'd0, ov1}, 32'd0);
        chk("d1_after_pop_occ", {30'd0, oc1}, 32'd0);

        // vector table on DEPTH=2
        sb.delete();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            iv2 = tbl[i].iv; id2 = tbl[i].id; or2 = tbl[i].ordy;
            #1;
            chk($sformatf("tbl%0d_ir", i), {31'd0, ir2}, {31'd0, tbl[i].e_ir});
            chk($sformatf("tbl%0d_ov", i), {31'd0, ov2}, {31'd0, tbl[i].e_ov});
            chk($sformatf("tbl%0d_occ", i), {29'd0, oc2}, {29'd0, tbl[i].e_occ});
            if (tbl[i].e_ov) chk($sformatf("tbl%0d_od", i), od2, tbl[i].e_od);
            if (ov2 && or2) sb_pop("tbl_order", od2);
            if (iv2 && ir2) sb.push_back(id2);
        end
        chk("tbl_sb_drained", sb.size(), 32'd0);

        // streaming 100 words through DEPTH=1, out_ready toggling
        sb.delete(); sent = 0; recv = 0; cyc = 0;
        while (recv < 100 && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            or1 = (cyc % 2 == 1);
            iv1 = (sent < 100);
            id1 = $urandom;
            #1;
            chk("stream_ir", {31'd0, ir1}, {31'd0, sb.size() < 2});
            chk("stream_ov", {31'd0, ov1}, {31'd0, sb.size() > 0});
            or1 = ~or1; #1;
            chk("stream_ir_indep", {31'd0, ir1}, {31'd0, sb.size() < 2});
            or1 = ~or1; #1;
            if (ov1 && or1) begin sb_pop("stream_order", od1); recv++; end
            if (iv1 && ir1) begin sb.push_back(id1); sent++; end
        end
        iv1 = 1'b0;
        chk("stream_received", recv, 32'd100);

        // flush with hold and a pending input at occupancy 3
        or2 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); iv2 = 1'b1; id2 = 32'h11 * (i + 1);
        end
        @(negedge clk); iv2 = 1'b0; #1;
        chk("fl_pre_occ", {29'd0, oc2}, 32'd3);
        f2 = 1'b1; h2 = 1'b1; iv2 = 1'b1; id2 = 32'h77; #1;
        chk("fl_hold_ir", {31'd0, ir2}, 32'd0);
        chk("fl_hold_ov", {31'd0, ov2}, 32'd0);
        @(negedge clk); f2 = 1'b0; h2 = 1'b0; iv2 = 1'b0; #1;
        chk("fl_occ", {29'd0, oc2}, 32'd0);
        chk("fl_ov", {31'd0, ov2}, 32'd0);
        chk("fl_od", od2, 32'd0);
        chk("fl_ir", {31'd0, ir2}, 32'd1);
        @(negedge clk); iv2 = 1'b1; id2 = 32'h55; or2 = 1'b1;
        @(negedge clk); iv2 = 1'b0;
        @(negedge clk); #1;
        chk("fl_next_ov", {31'd0, ov2}, 32'd1);
        chk("fl_next_od", od2, 32'h55);
        @(negedge clk); #1;
        chk("fl_next_drained", {31'd0, ov2}, 32'd0);

        // hold for 5 cycles at occupancy 2
        sb.delete(); or2 = 1'b0;
        @(negedge clk); iv2 = 1'b1; id2 = 32'h101; sb.push_back(id2);
        @(negedge clk); iv2 = 1'b1; id2 = 32'h202; sb.push_back(id2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); h2 = 1'b1; iv2 = 1'b1; id2 = 32'h999; or2 = 1'b1; #1;
            chk("hold_ir", {31'd0, ir2}, 32'd0);
            chk("hold_ov", {31'd0, ov2}, 32'd0);
            chk("hold_occ", {29'd0, oc2}, 32'd2);
        end
        cyc = 0;
        @(negedge clk); h2 = 1'b0; iv2 = 1'b0;
        while (sb.size() > 0 && cyc < 10) begin
            #1;
            if (ov2) sb_pop("hold_release_order", od2);
            @(negedge clk); cyc++;
        end
        chk("hold_release_drained", sb.size(), 32'd0);
        chk("hold_release_cycles", cyc, 32'd2);
        #1;
        chk("hold_release_occ", {29'd0, oc2}, 32'd0);

        // asynchronous reset between edges while DEPTH=1 is FULL
        or1 = 1'b0;
        @(negedge clk); iv1 = 1'b1; id1 = 32'hC0DE0001;
        @(negedge clk); iv1 = 1'b1; id1 = 32'hC0DE0002;
        @(negedge clk); iv1 = 1'b0; #1;
        chk("ar_pre_occ", {30'd0, oc1}, 32'd2);
        chk("ar_pre_ir", {31'd0, ir1}, 32'd0);
        #2 a_reset = 1'b1;
        #1;
        chk("ar_ov", {31'd0, ov1}, 32'd0);
        chk("ar_occ", {30'd0, oc1}, 32'd0);
        chk("ar_od", od1, 32'd0);
        chk("ar_ir", {31'd0, ir1}, 32'd1);
        @(negedge clk); a_reset = 1'b0;
        @(negedge clk); #1;
        chk("ar_after_occ", {30'd0, oc1}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
